ov7670_capture_px: RTL
======================

Name: ov7670_capture_px

Overview:
Parametrised successor to the single-byte OV7670 capture path. Assembles 1- or 2-byte pixels from the 8-bit camera bus, optionally decimates by 1/2/4 in both axes and optionally inverts data. Writes whole pixels to the frame buffer with a sequential address. Adds frame-boundary tracking, per-frame arming, a frame counter and line-length/overflow error flags; sits between the camera pins and the frame-buffer BRAM write port.

Parameters:
H_ACTIVE, 640, active pixels per line (pixels, not bytes)
V_ACTIVE, 480, active lines per frame
BYTES_PER_PIXEL, 2, bytes per pixel, legal 1 or 2
DECIM, 1, decimation factor per axis, legal 1, 2, 4
ADDR_W, 19, frame-buffer address width; must hold (H_ACTIVE/DECIM)*(V_ACTIVE/DECIM)
DATA_W, 8*BYTES_PER_PIXEL, output pixel width (derived, not overridden)

Ports:
pclk  in  1  camera pixel clock
rst_n  in  1  asynchronous active-low reset
vsync  in  1  frame sync, high between frames
href  in  1  line valid, high during active bytes
din  in  8  camera data byte
capture_en  in  1  arm request, sampled once per frame while vsync high
invert  in  1  1 = output bitwise-inverted pixel; sampled with capture_en
addr  out  ADDR_W  write address
dout  out  DATA_W  write data
we  out  1  write strobe, one pclk per pixel
frame_done  out  1  one-cycle pulse at end of each armed frame
frame_cnt  out  8  completed armed frames, wraps 255->0
line_err  out  1  sticky: a line had byte count != H_ACTIVE*BYTES_PER_PIXEL; cleared at next frame start
ovf_err  out  1  sticky: a write was attempted past the last address; cleared at next frame start

Behaviour:
- Reset (async, rst_n low): addr=0, dout=0, we=0, frame_done=0, frame_cnt=0, line_err=0, ovf_err=0; internal counters 0; state WAIT_SYNC; armed=0, inv=0.
- States: WAIT_SYNC -> SYNC on vsync=1. SYNC: every cycle armed<=capture_en, inv<=invert, write index=0, hcnt=vcnt=0, byte phase=0, errors cleared. SYNC -> ACTIVE on vsync=0. ACTIVE -> SYNC on vsync=1; if armed, frame_done=1 for that one cycle and frame_cnt++.
- Reset or startup mid-frame: no writes until a full vsync high period has been seen (WAIT_SYNC ignores href).
- Byte assembly (ACTIVE, href=1): byte phase counts 0..BYTES_PER_PIXEL-1. First byte goes to the MSBs. The pixel is complete on the last phase; hcnt++ (pixel column).
- Write rule: pixel complete AND armed AND hcnt%DECIM==0 AND vcnt%DECIM==0 (pre-increment hcnt) AND hcnt<H_ACTIVE AND vcnt<V_ACTIVE.
- Write timing: on the cycle after the last byte is sampled, we=1, dout=pixel (or ~pixel if inv), and addr=current write index. The write index increments after each write. When we=0, addr and dout hold their last values.
- Capacity: if the write index equals (H_ACTIVE/DECIM)*(V_ACTIVE/DECIM), the write is suppressed (we stays 0) and ovf_err=1.
- Line end (href falling edge in ACTIVE):
  - If bytes counted != H_ACTIVE*BYTES_PER_PIXEL, set line_err.
  - vcnt++, hcnt=0, byte phase=0; a partial pixel is discarded.
- Extra lines with vcnt>=V_ACTIVE are not written and do not set ovf_err.
- vsync rising mid-line: line is abandoned with no line_err for it; frame_done still fires if armed.
- Not armed: counters and error flags run normally; we never asserts; frame_cnt and frame_done are unchanged.

Test Plan:
- H=4,V=2,BPP=2,DECIM=1, armed, bytes 0x01..0x10 -> 8 writes addr 0..7, dout 0x0102,0x0304,...,0x0F10; frame_done 1 cycle after vsync rise; frame_cnt=1.
- Same frame with invert=1 during SYNC -> dout 0xFEFD,... ; toggling invert mid-frame has no effect until the next SYNC.
- DECIM=2, H=8,V=4 -> writes only for even row/col pixels, addr 0..7, 8 writes total.
- Line with 7 bytes (BPP=2,H=4) -> line_err=1, 3 writes for that line, last byte dropped; line_err clears at next vsync.
- capture_en=0 at SYNC -> no we for the frame, frame_cnt unchanged; capture_en=1 next SYNC -> normal capture.
- rst_n pulse mid-line -> all outputs 0 immediately; href activity ignored until vsync high then low; 5th extra line (V=4) causes no writes.

Source files
------------

// File: rtl/ov7670_capture_px.sv
// OV7670 byte-bus capture: assembles 1/2-byte pixels, decimates, optionally inverts,
// and writes whole pixels to a frame buffer while tracking frame boundaries and errors.
module ov7670_capture_px #(
    parameter int H_ACTIVE        = 640,
    parameter int V_ACTIVE        = 480,
    parameter int BYTES_PER_PIXEL = 2,
    parameter int DECIM           = 1,
    parameter int ADDR_W          = 19,
    localparam int DATA_W         = 8 * BYTES_PER_PIXEL
) (
    input  logic              pclk,
    input  logic              rst_n,
    input  logic              vsync,
    input  logic              href,
    input  logic [7:0]        din,
    input  logic              capture_en,
    input  logic              invert,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] dout,
    output logic              we,
    output logic              frame_done,
    output logic [7:0]        frame_cnt,
    output logic              line_err,
    output logic              ovf_err
);

    localparam logic [15:0]       H_LIM      = 16'(H_ACTIVE);
    localparam logic [15:0]       V_LIM      = 16'(V_ACTIVE);
    localparam logic [15:0]       LINE_BYTES = 16'(H_ACTIVE * BYTES_PER_PIXEL);
    localparam logic [15:0]       DECIM_MASK = 16'(DECIM - 1);
    localparam logic              LAST_PHASE = 1'(BYTES_PER_PIXEL - 1);
    localparam logic [ADDR_W:0]   CAPACITY   = (ADDR_W + 1)'((H_ACTIVE / DECIM) * (V_ACTIVE / DECIM));
    localparam logic [ADDR_W:0]   IDX_ONE    = (ADDR_W + 1)'(1);

    typedef enum logic [1:0] {
        WAIT_SYNC = 2'd0,
        SYNC      = 2'd1,
        ACTIVE    = 2'd2
    } state_t;

    state_t              state_r;
    state_t              state_nxt_s;

    logic                armed_r;
    logic                inv_r;
    logic                href_d_r;
    logic                phase_r;
    logic [15:0]         hcnt_r;
    logic [15:0]         vcnt_r;
    logic [15:0]         line_bytes_r;
    logic [DATA_W-1:0]   pix_acc_r;
    logic [ADDR_W:0]     wr_idx_r;
    logic [ADDR_W-1:0]   addr_r;
    logic [DATA_W-1:0]   dout_r;
    logic                we_r;
    logic                frame_done_r;
    logic [7:0]          frame_cnt_r;
    logic                line_err_r;
    logic                ovf_err_r;

    logic                active_s;
    logic                frame_end_s;
    logic                byte_s;
    logic                pix_done_s;
    logic                line_end_s;
    logic                pos_ok_s;
    logic                wr_req_s;
    logic                cap_full_s;
    logic [DATA_W-1:0]   pix_next_s;

    function automatic logic [DATA_W-1:0] format_pixel(input logic [DATA_W-1:0] pix, input logic inv);
        return inv ? ~pix : pix;
    endfunction

    // Counters saturate so an overlong line cannot wrap back into the active window.
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // State register.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= WAIT_SYNC;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic and per-cycle datapath strobes.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            WAIT_SYNC: begin
                if (vsync) state_nxt_s = SYNC;
                else       state_nxt_s = WAIT_SYNC;
            end
            SYNC: begin
                if (!vsync) state_nxt_s = ACTIVE;
                else        state_nxt_s = SYNC;
            end
            ACTIVE: begin
                if (vsync) state_nxt_s = SYNC;
                else       state_nxt_s = ACTIVE;
            end
            default: state_nxt_s = WAIT_SYNC;
        endcase

        active_s    = (state_r == ACTIVE) && !vsync;
        frame_end_s = (state_r == ACTIVE) && vsync;
        byte_s      = active_s && href;
        pix_done_s  = byte_s && (phase_r == LAST_PHASE);
        line_end_s  = active_s && href_d_r && !href;
        // Position test uses the column index before this pixel's increment.
        pos_ok_s    = ((hcnt_r & DECIM_MASK) == 16'd0) && ((vcnt_r & DECIM_MASK) == 16'd0) &&
                      (hcnt_r < H_LIM) && (vcnt_r < V_LIM);
        wr_req_s    = pix_done_s && armed_r && pos_ok_s;
        cap_full_s  = (wr_idx_r == CAPACITY);
        pix_next_s  = DATA_W'({pix_acc_r, din});
    end

    // Datapath: frame arming, byte assembly, write generation and status flags.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            armed_r      <= 1'b0;
            inv_r        <= 1'b0;
            href_d_r     <= 1'b0;
            phase_r      <= 1'b0;
            hcnt_r       <= 16'd0;
            vcnt_r       <= 16'd0;
            line_bytes_r <= 16'd0;
            pix_acc_r    <= '0;
            wr_idx_r     <= '0;
            addr_r       <= '0;
            dout_r       <= '0;
            we_r         <= 1'b0;
            frame_done_r <= 1'b0;
            frame_cnt_r  <= 8'd0;
            line_err_r   <= 1'b0;
            ovf_err_r    <= 1'b0;
        end else begin
            we_r         <= 1'b0;
            frame_done_r <= 1'b0;
            href_d_r     <= active_s ? href : 1'b0;
            if (state_r == SYNC) begin
                armed_r      <= capture_en;
                inv_r        <= invert;
                phase_r      <= 1'b0;
                hcnt_r       <= 16'd0;
                vcnt_r       <= 16'd0;
                line_bytes_r <= 16'd0;
                wr_idx_r     <= '0;
                line_err_r   <= 1'b0;
                ovf_err_r    <= 1'b0;
            end else if (frame_end_s) begin
                if (armed_r) begin
                    frame_done_r <= 1'b1;
                    frame_cnt_r  <= frame_cnt_r + 8'd1;
                end
            end else if (byte_s) begin
                line_bytes_r <= sat_inc(line_bytes_r);
                pix_acc_r    <= pix_next_s;
                if (pix_done_s) begin
                    phase_r <= 1'b0;
                    hcnt_r  <= sat_inc(hcnt_r);
                    if (wr_req_s) begin
                        if (cap_full_s) begin
                            ovf_err_r <= 1'b1;
                        end else begin
                            we_r     <= 1'b1;
                            addr_r   <= wr_idx_r[ADDR_W-1:0];
                            dout_r   <= format_pixel(pix_next_s, inv_r);
                            wr_idx_r <= wr_idx_r + IDX_ONE;
                        end
                    end
                end else begin
                    phase_r <= phase_r + 1'b1;
                end
            end else if (line_end_s) begin
                // A partial pixel at line end is simply dropped with the phase reset.
                if (line_bytes_r != LINE_BYTES) begin
                    line_err_r <= 1'b1;
                end
                vcnt_r       <= sat_inc(vcnt_r);
                hcnt_r       <= 16'd0;
                phase_r      <= 1'b0;
                line_bytes_r <= 16'd0;
            end
        end
    end

    assign addr       = addr_r;
    assign dout       = dout_r;
    assign we         = we_r;
    assign frame_done = frame_done_r;
    assign frame_cnt  = frame_cnt_r;
    assign line_err   = line_err_r;
    assign ovf_err    = ovf_err_r;

endmodule
